circuit_sweep_ctrl: RTL and testbench
=====================================

// Module: circuit_sweep_ctrl
// PURPOSE
//   Sequencer for the 3-input combinational function z = x1 | (x2 & x3).
//   On start, drives all 8 input vectors into an external instance of that function.
//   Waits a settle interval per vector, then samples z and compares it against an internal golden model.
//   Reports mismatch count, first failing vector and pass/fail with a start/busy/done handshake.
//   Used as the self-check front-end for lab circuits and for on-bench regression.
// PARAMETERS
//   SETTLE_CYCLES  2  clock cycles between driving a vector and sampling z (0 allowed)
//   ERR_W          4  width of err_count; counter saturates at 2**ERR_W-1
// PORTS
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   start       in   1      request a sweep; sampled only in IDLE
//   abort       in   1      synchronous cancel of a running sweep
//   x1,x2,x3    out  1 ea   stimulus to circuit under check; vec = {x1,x2,x3}, x1 = MSB
//   z           in   1      response of circuit under check
//   busy        out  1      high in DRIVE/SETTLE/SAMPLE
//   done        out  1      one-cycle pulse when a sweep completes (not on abort)
//   pass        out  1      err_count==0 at completion; held until next start
//   err_count   out  ERR_W  mismatches in the last sweep, saturating
//   fail_valid  out  1      at least one mismatch recorded
//   fail_vec    out  3      first mismatching vector {x1,x2,x3}
// BEHAVIOUR
//   Reset (async on rst_n low, no clock needed): state=IDLE.
//     All outputs 0: x*, busy, done, pass, err_count, fail_valid, fail_vec.
//   All outputs are registered; no combinational path from z or start to any output.
//   States and transitions:
//     IDLE   : x*=000. When start=1, clear err_count, fail_valid, fail_vec and pass; vec=0; go to DRIVE.
//     DRIVE  : present vec on x*; 1 cycle. Go to SETTLE if SETTLE_CYCLES>0, else SAMPLE.
//     SETTLE : hold x*; count SETTLE_CYCLES cycles, then go to SAMPLE.
//     SAMPLE : exp = vec[2] | (vec[1] & vec[0]).
//              If z!=exp: err_count+=1 (saturating); if !fail_valid, latch fail_vec=vec and set fail_valid.
//              If vec==7, go to DONE; else vec+=1 (no wrap) and go to DRIVE.
//     DONE   : done=1 for this cycle only; pass=(err_count==0); x*=000; go to IDLE.
//   Latency: (2+SETTLE_CYCLES) cycles per vector.
//     done is high 8*(2+SETTLE_CYCLES)+1 cycles after the edge that samples start.
//   start while busy or in DONE: ignored, not queued.
//   start held high: a new sweep begins on the first IDLE cycle after DONE.
//   abort in DRIVE/SETTLE/SAMPLE: next state IDLE, x*=000, no done pulse.
//     err_count, fail_* and pass keep their partial values.
//   abort in IDLE: no effect.
//   abort together with start in IDLE: start wins.
//   abort and SAMPLE of vec 7 in the same cycle: abort wins (no done).
//   rst_n low mid-sweep: immediate return to the reset values above.
//   z is treated as synchronous to clk; a z of X/Z counts as a mismatch in simulation.
// STRUCTURE
//   Package circuit_sweep_pkg: state enum {IDLE,DRIVE,SETTLE,SAMPLE,DONE}, VEC_W=3, LAST_VEC=3'd7.
//   Sub-module golden_ref: combinational, in vec[2:0], out exp = vec[2] | (vec[1]&vec[0]).
//     Isolated so other functions can be swapped in later.
//   Settle counter width: $clog2(SETTLE_CYCLES+1), minimum 1.
// TESTING  (bench connects a real 3-input instance or a fault model to x*/z)
//   1 Reset: rst_n=0 with no clk -> all outputs 0. Release -> stays IDLE with x*=000 while start=0.
//   2 Good DUT, S=2: 1-cycle start -> busy next cycle; x* steps 000..111, each held 4 cycles.
//     done pulse 33 cycles after the start edge; pass=1, err_count=0, fail_valid=0.
//   3 z stuck-at-0: err_count=5, fail_valid=1, fail_vec=3'b011, pass=0.
//     With ERR_W=2: err_count saturates at 3.
//   4 abort while vec=100: IDLE next cycle, x*=000, busy=0, no done.
//     A following start runs a full clean sweep (pass=1).
//   5 start held high for 100 cycles, S=0: sweeps of 17 cycles back-to-back with one IDLE cycle between.
//     done pulses exactly 1 cycle each.
//   6 rst_n low for 1 ns at vec=101, between clock edges: outputs 0 immediately.
//     Sweep does not resume after release.

Source files
------------

// File: rtl/circuit_sweep_pkg.sv
// Shared types and constants for the circuit sweep sequencer.
// Holds the FSM state encoding and the stimulus vector geometry.
package circuit_sweep_pkg;

  localparam int VEC_W = 3;
  localparam logic [VEC_W-1:0] LAST_VEC = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  function automatic logic is_sweep_state(input state_t s);
    return (s == DRIVE) || (s == SETTLE) || (s == SAMPLE);
  endfunction

endpackage

// File: rtl/circuit_sweep_ctrl_golden_ref.sv
// Golden model of the circuit under check: z = x1 | (x2 & x3), vec = {x1,x2,x3}.
// Kept separate so a different reference function can be dropped in.
module golden_ref
  import circuit_sweep_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             exp
);

  assign exp = vec[2] | (vec[1] & vec[0]);

endmodule

// File: rtl/circuit_sweep_ctrl.sv
// Sweep sequencer: drives all 8 vectors into an external circuit, samples z after a
// settle interval, compares against golden_ref and reports error count / first failure.
module circuit_sweep_ctrl
  import circuit_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             x1,
  output logic             x2,
  output logic             x3,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t             r_state, w_state_nxt;
  logic [VEC_W-1:0]   r_vec, w_vec_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [ERR_W-1:0]   r_err, w_err_nxt;
  logic               r_fail_valid, w_fail_valid_nxt;
  logic [VEC_W-1:0]   r_fail_vec, w_fail_vec_nxt;
  logic               r_pass, w_pass_nxt;
  logic [VEC_W-1:0]   r_x, w_x_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               w_exp;
  logic               w_hit;

  golden_ref u_golden (
    .vec (r_vec),
    .exp (w_exp)
  );

  // NOTE: the mismatch sits in the else branch so an X/Z on z (unknown compare) counts as a miss.
  always_comb begin
    w_hit = 1'b0;
    if (z == w_exp) w_hit = 1'b0;
    else            w_hit = 1'b1;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_vec_nxt        = r_vec;
    w_cnt_nxt        = r_cnt;
    w_err_nxt        = r_err;
    w_fail_valid_nxt = r_fail_valid;
    w_fail_vec_nxt   = r_fail_vec;
    w_pass_nxt       = r_pass;

    if (is_sweep_state(r_state) && abort) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            w_err_nxt        = '0;
            w_fail_valid_nxt = 1'b0;
            w_fail_vec_nxt   = '0;
            w_pass_nxt       = 1'b0;
            w_vec_nxt        = '0;
            w_state_nxt      = DRIVE;
          end
        end
        DRIVE: begin
          if (SETTLE_CYCLES > 0) begin
            w_cnt_nxt   = '0;
            w_state_nxt = SETTLE;
          end else begin
            w_state_nxt = SAMPLE;
          end
        end
        SETTLE: begin
          if (r_cnt == SETTLE_LAST) w_state_nxt = SAMPLE;
          else                      w_cnt_nxt   = r_cnt + 1'b1;
        end
        SAMPLE: begin
          if (w_hit) begin
            if (r_err != ERR_MAX) w_err_nxt = r_err + 1'b1;
            if (!r_fail_valid) begin
              w_fail_valid_nxt = 1'b1;
              w_fail_vec_nxt   = r_vec;
            end
          end
          // pass is resolved on entry to DONE so it is valid alongside the done pulse.
          if (r_vec == LAST_VEC) begin
            w_pass_nxt  = (w_err_nxt == '0);
            w_state_nxt = DONE;
          end else begin
            w_vec_nxt   = r_vec + 1'b1;
            w_state_nxt = DRIVE;
          end
        end
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end

    w_busy_nxt = is_sweep_state(w_state_nxt);
    w_x_nxt    = w_busy_nxt ? w_vec_nxt : '0;
    w_done_nxt = (w_state_nxt == DONE);
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_vec        <= '0;
      r_cnt        <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
      r_pass       <= 1'b0;
      r_x          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vec        <= w_vec_nxt;
      r_cnt        <= w_cnt_nxt;
      r_err        <= w_err_nxt;
      r_fail_valid <= w_fail_valid_nxt;
      r_fail_vec   <= w_fail_vec_nxt;
      r_pass       <= w_pass_nxt;
      r_x          <= w_x_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign x1         = r_x[2];
  assign x2         = r_x[1];
  assign x3         = r_x[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// Directed bench for circuit_sweep_ctrl: good circuit, stuck-at-0 fault, abort,
// back-to-back sweeps with no settle, and asynchronous reset mid-sweep.
module tb_circuit_sweep_ctrl;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n = 1'b1;
  logic abort = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic fault_a = 1'b0;

  logic xa1, xa2, xa3, z_a, busy_a, done_a, pass_a, fv_a;
  logic [3:0] err_a;
  logic [2:0] fvec_a;
  logic xb1, xb2, xb3, z_b, busy_b, done_b, pass_b, fv_b;
  logic [1:0] err_b;
  logic [2:0] fvec_b;
  logic xc1, xc2, xc3, z_c, busy_c, done_c, pass_c, fv_c;
  logic [3:0] err_c;
  logic [2:0] fvec_c;

  int checks = 0;
  int failures = 0;

  always #5 if (clk_run) clk = ~clk;

  // Circuits under check: a = good or stuck-at-0, b = stuck-at-0, c = good.
  assign z_a = fault_a ? 1'b0 : (xa1 | (xa2 & xa3));
  assign z_b = 1'b0;
  assign z_c = xc1 | (xc2 & xc3);

  circuit_sweep_ctrl #(.SETTLE_CYCLES(2), .ERR_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
    .x1(xa1), .x2(xa2), .x3(xa3), .z(z_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_valid(fv_a), .fail_vec(fvec_a)
  );

  circuit_sweep_ctrl #(.SETTLE_CYCLES(2), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
    .x1(xb1), .x2(xb2), .x3(xb3), .z(z_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_valid(fv_b), .fail_vec(fvec_b)
  );

  circuit_sweep_ctrl #(.SETTLE_CYCLES(0), .ERR_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort),
    .x1(xc1), .x2(xc2), .x3(xc3), .z(z_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .fail_valid(fv_c), .fail_vec(fvec_c)
  );

  wire [13:0] snap_a = {xa1, xa2, xa3, busy_a, done_a, pass_a, err_a, fv_a, fvec_a};
  wire [11:0] snap_b = {xb1, xb2, xb3, busy_b, done_b, pass_b, err_b, fv_b, fvec_b};
  wire [13:0] snap_c = {xc1, xc2, xc3, busy_c, done_c, pass_c, err_c, fv_c, fvec_c};

  // Leaves the bench at the falling edge of the first cycle after the start-sampling edge.
  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done_a === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({snap_a, snap_b, snap_c} !== 40'd0) begin
      failures++;
      $display("FAIL reset_async got a=%h b=%h c=%h exp all zero", snap_a, snap_b, snap_c);
    end
    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({busy_a, done_a, xa1, xa2, xa3} !== 5'b0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d got busy/done/x=%b%b%b%b%b exp 00000",
                 k, busy_a, done_a, xa1, xa2, xa3);
      end
    end
  endtask

  task automatic test_good_sweep();
    logic       exp_busy, exp_done;
    logic [2:0] exp_x;
    pulse_start_a();
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge clk);
      exp_busy = (k <= 32);
      exp_done = (k == 33);
      exp_x    = exp_busy ? 3'((k - 1) / 4) : 3'd0;
      checks++;
      if ({busy_a, done_a, xa1, xa2, xa3} !== {exp_busy, exp_done, exp_x}) begin
        failures++;
        $display("FAIL good_seq cycle=%0d got busy/done/x=%b/%b/%b%b%b exp %b/%b/%03b",
                 k, busy_a, done_a, xa1, xa2, xa3, exp_busy, exp_done, exp_x);
      end
    end
    checks++;
    if ({pass_a, err_a, fv_a} !== {1'b1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL good_result got pass=%b err=%0d fv=%b exp pass=1 err=0 fv=0",
               pass_a, err_a, fv_a);
    end
  endtask

  task automatic test_stuck_at();
    bit seen;
    fault_a = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    wait_done_a(40, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL stuck_done_timeout got no done exp done within 40 cycles");
    end
    checks++;
    if (done_b !== 1'b1) begin
      failures++;
      $display("FAIL stuck_done_b got done_b=%b exp 1", done_b);
    end
    @(negedge clk);
    checks++;
    if ({err_a, fv_a, fvec_a, pass_a} !== {4'd5, 1'b1, 3'b011, 1'b0}) begin
      failures++;
      $display("FAIL stuck_result got err=%0d fv=%b fvec=%03b pass=%b exp err=5 fv=1 fvec=011 pass=0",
               err_a, fv_a, fvec_a, pass_a);
    end
    checks++;
    if ({err_b, fv_b, fvec_b, pass_b} !== {2'd3, 1'b1, 3'b011, 1'b0}) begin
      failures++;
      $display("FAIL stuck_saturate got err=%0d fv=%b fvec=%03b pass=%b exp err=3 fv=1 fvec=011 pass=0",
               err_b, fv_b, fvec_b, pass_b);
    end
    fault_a = 1'b0;
  endtask

  task automatic test_abort();
    bit seen;
    int ndone;
    pulse_start_a();
    for (int k = 2; k <= 18; k++) @(negedge clk);
    checks++;
    if ({busy_a, xa1, xa2, xa3} !== 4'b1100) begin
      failures++;
      $display("FAIL abort_pre got busy/x=%b/%b%b%b exp 1/100", busy_a, xa1, xa2, xa3);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy_a, done_a, xa1, xa2, xa3} !== 5'b0) begin
      failures++;
      $display("FAIL abort_idle got busy/done/x=%b/%b/%b%b%b exp 0/0/000",
               busy_a, done_a, xa1, xa2, xa3);
    end
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_a === 1'b1 || busy_a === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL abort_no_done got active_cycles=%0d exp 0", ndone);
    end
    checks++;
    if ({err_a, pass_a} !== {4'd0, 1'b0}) begin
      failures++;
      $display("FAIL abort_partial got err=%0d pass=%b exp err=0 pass=0", err_a, pass_a);
    end
    pulse_start_a();
    wait_done_a(40, seen);
    @(negedge clk);
    checks++;
    if (!seen || {pass_a, err_a, fv_a} !== {1'b1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL abort_rerun got seen=%b pass=%b err=%0d fv=%b exp seen=1 pass=1 err=0 fv=0",
               seen, pass_a, err_a, fv_a);
    end
  endtask

  task automatic test_back_to_back();
    int         p, ndone, nbad;
    logic       exp_busy, exp_done;
    logic [2:0] exp_x;
    bit         seen;
    ndone = 0;
    nbad  = 0;
    @(negedge clk);
    start_c = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      p        = ((k - 1) % 18) + 1;
      exp_busy = (p <= 16);
      exp_done = (p == 17);
      exp_x    = exp_busy ? 3'((p - 1) / 2) : 3'd0;
      if (done_c === 1'b1) ndone++;
      checks++;
      if ({busy_c, done_c, xc1, xc2, xc3} !== {exp_busy, exp_done, exp_x}) begin
        failures++;
        nbad++;
        if (nbad < 6)
          $display("FAIL b2b_seq cycle=%0d got busy/done/x=%b/%b/%b%b%b exp %b/%b/%03b",
                   k, busy_c, done_c, xc1, xc2, xc3, exp_busy, exp_done, exp_x);
      end
    end
    start_c = 1'b0;
    checks++;
    if (ndone != 5) begin
      failures++;
      $display("FAIL b2b_done_count got %0d exp 5", ndone);
    end
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done_c === 1'b1) seen = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (!seen || {pass_c, err_c, busy_c} !== {1'b1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_final got seen=%b pass=%b err=%0d busy=%b exp seen=1 pass=1 err=0 busy=0",
               seen, pass_c, err_c, busy_c);
    end
  endtask

  task automatic test_reset_mid();
    int nact;
    pulse_start_a();
    for (int k = 2; k <= 22; k++) @(negedge clk);
    checks++;
    if ({busy_a, xa1, xa2, xa3} !== 4'b1101) begin
      failures++;
      $display("FAIL rst_mid_pre got busy/x=%b/%b%b%b exp 1/101", busy_a, xa1, xa2, xa3);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (snap_a !== 14'd0) begin
      failures++;
      $display("FAIL rst_mid_async got %h exp 0", snap_a);
    end
    #1 rst_n = 1'b1;
    nact = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy_a !== 1'b0 || done_a !== 1'b0 || {xa1, xa2, xa3} !== 3'b000) nact++;
    end
    checks++;
    if (nact != 0) begin
      failures++;
      $display("FAIL rst_mid_no_resume got active_cycles=%0d exp 0", nact);
    end
  endtask

  initial begin
    test_reset();
    test_good_sweep();
    test_stuck_at();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
